rob_ctrl: RTL and testbench

Sequencing controller for the reorder buffer storage in the out-of-order RISC-V core. It owns the head and tail pointers, per-entry busy/done/mispredict status and destination register, and drives the ROB RAM's allocate and writeback enables. It grants issue-stage allocations, marks entries complete from the CDB, and retires one entry per cycle in order to the register file. A mispredicted branch reaching the head triggers a one-cycle flush.

---
 rtl/rob_pkg.sv | 23 ++
 rtl/rob_ptr.sv | 30 +++
 rtl/rob_ctrl.sv | 153 +++++++++++++++
 tb/tb_rob_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder-buffer controller.
// Issue, CDB and commit logic all see the same entry layout and depth.
package rob_pkg;

    localparam int ROB_ADDR_W = 3;
    localparam int ROB_REG_W  = 5;
    localparam int ROB_DEPTH  = 1 << ROB_ADDR_W;

    typedef logic [ROB_ADDR_W-1:0] rob_tag_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rob_state_e;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic                 mp;
        logic [ROB_REG_W-1:0] rd;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping pointer used for the ROB head and tail.
// A load takes priority over an increment.
module rob_ptr
    import rob_pkg::*;
#(
    parameter int W = ROB_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (load) begin
            ptr_reg <= load_val;
        end else if (inc) begin
            ptr_reg <= ptr_reg + W'(1);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer sequencing: in-order allocate/retire, CDB completion,
// and a one-cycle flush when a mispredicted branch retires.
module rob_ctrl #(
    parameter int ADDR_WIDTH     = 3,
    parameter int ROB_DEPTH      = 1 << ADDR_WIDTH,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_req,
    input  logic [REG_ADDR_WIDTH-1:0] alloc_rd,
    output logic                      alloc_ready,
    output logic [ADDR_WIDTH-1:0]     alloc_tag,
    input  logic                      cdb_valid,
    input  logic [ADDR_WIDTH-1:0]     cdb_tag,
    input  logic                      cdb_mispredict,
    input  logic                      commit_ready,
    output logic                      ram_alloc_en,
    output logic                      ram_wb_en,
    output logic [ADDR_WIDTH-1:0]     ram_head_addr,
    output logic                      commit_valid,
    output logic [REG_ADDR_WIDTH-1:0] commit_rd,
    output logic                      flush,
    output logic [ADDR_WIDTH:0]       count,
    output logic                      full,
    output logic                      empty,
    output logic                      cdb_err
);

    import rob_pkg::*;

    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    rob_state_e            state_reg;
    logic                  flush_reg;
    logic                  cdb_err_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    rob_entry_t            entry_q [ROB_DEPTH];

    logic is_run;
    logic alloc_fire;
    logic cdb_hit;
    logic commit_fire;

    assign is_run      = (state_reg == RUN);
    assign full        = (count_reg == (ADDR_WIDTH+1)'(ROB_DEPTH));
    assign empty       = (count_reg == '0);
    assign alloc_ready = !full && is_run;
    assign alloc_fire  = alloc_req && alloc_ready;
    assign cdb_hit     = cdb_valid && is_run && entry_q[cdb_tag].busy;
    // done is registered, so a CDB write to the head retires a cycle later
    assign commit_fire = is_run && !empty && entry_q[head].done && commit_ready;

    rob_ptr #(.W(ADDR_WIDTH)) u_head (
        .clk      (clk),
        .rst      (rst),
        .inc      (commit_fire),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (head)
    );

    // On flush the tail collapses onto the already-advanced head
    rob_ptr #(.W(ADDR_WIDTH)) u_tail (
        .clk      (clk),
        .rst      (rst),
        .inc      (alloc_fire),
        .load     (!is_run),
        .load_val (head),
        .ptr      (tail)
    );

    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
        rob_entry_t entry_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (!is_run) begin
                entry_reg.busy <= 1'b0;
                entry_reg.done <= 1'b0;
                entry_reg.mp   <= 1'b0;
            end else begin
                if (commit_fire && head == ADDR_WIDTH'(gi)) begin
                    entry_reg.busy <= 1'b0;
                end
                if (alloc_fire && tail == ADDR_WIDTH'(gi)) begin
                    entry_reg.busy <= 1'b1;
                    entry_reg.done <= 1'b0;
                    entry_reg.mp   <= 1'b0;
                    entry_reg.rd   <= alloc_rd;
                end
                if (cdb_hit && cdb_tag == ADDR_WIDTH'(gi)) begin
                    entry_reg.done <= 1'b1;
                    entry_reg.mp   <= cdb_mispredict;
                end
            end
        end

        assign entry_q[gi] = entry_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= RUN;
            flush_reg   <= 1'b0;
            cdb_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (cdb_valid && !entry_q[cdb_tag].busy) begin
                        cdb_err_reg <= 1'b1;
                    end
                    if (commit_fire && entry_q[head].mp) begin
                        state_reg <= FLUSH;
                        flush_reg <= 1'b1;
                    end
                end
                FLUSH: begin
                    state_reg <= RUN;
                    flush_reg <= 1'b0;
                end
                default: begin
                    state_reg <= RUN;
                    flush_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (!is_run) begin
            count_reg <= '0;
        end else if (alloc_fire && !commit_fire) begin
            count_reg <= count_reg + (ADDR_WIDTH+1)'(1);
        end else if (commit_fire && !alloc_fire) begin
            count_reg <= count_reg - (ADDR_WIDTH+1)'(1);
        end
    end

    assign alloc_tag     = tail;
    assign ram_alloc_en  = alloc_fire;
    assign ram_wb_en     = cdb_hit;
    assign ram_head_addr = head;
    assign commit_valid  = commit_fire;
    assign commit_rd     = commit_fire ? entry_q[head].rd : '0;
    assign flush         = flush_reg;
    assign count         = count_reg;
    assign cdb_err       = cdb_err_reg;

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: fill/wrap, in-order retire, mispredict flush,
// commit back-pressure, CDB error and reset during flush.
module tb_rob_ctrl;

    localparam int AW = 3;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_req;
    logic [RW-1:0] alloc_rd;
    logic          alloc_ready;
    logic [AW-1:0] alloc_tag;
    logic          cdb_valid;
    logic [AW-1:0] cdb_tag;
    logic          cdb_mispredict;
    logic          commit_ready;
    logic          ram_alloc_en;
    logic          ram_wb_en;
    logic [AW-1:0] ram_head_addr;
    logic          commit_valid;
    logic [RW-1:0] commit_rd;
    logic          flush;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          cdb_err;

    int checks = 0;
    int errors = 0;

    rob_ctrl #(.ADDR_WIDTH(AW), .ROB_DEPTH(8), .REG_ADDR_WIDTH(RW)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req      (alloc_req),
        .alloc_rd       (alloc_rd),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_mispredict (cdb_mispredict),
        .commit_ready   (commit_ready),
        .ram_alloc_en   (ram_alloc_en),
        .ram_wb_en      (ram_wb_en),
        .ram_head_addr  (ram_head_addr),
        .commit_valid   (commit_valid),
        .commit_rd      (commit_rd),
        .flush          (flush),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .cdb_err        (cdb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, ".alloc_ready"}, 32'(alloc_ready), 1);
        chk({pfx, ".empty"}, 32'(empty), 1);
        chk({pfx, ".full"}, 32'(full), 0);
        chk({pfx, ".count"}, 32'(count), 0);
        chk({pfx, ".alloc_tag"}, 32'(alloc_tag), 0);
        chk({pfx, ".head"}, 32'(ram_head_addr), 0);
        chk({pfx, ".commit_valid"}, 32'(commit_valid), 0);
        chk({pfx, ".commit_rd"}, 32'(commit_rd), 0);
        chk({pfx, ".flush"}, 32'(flush), 0);
        chk({pfx, ".cdb_err"}, 32'(cdb_err), 0);
        chk({pfx, ".ram_alloc_en"}, 32'(ram_alloc_en), 0);
        chk({pfx, ".ram_wb_en"}, 32'(ram_wb_en), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; alloc_req = 1'b0; alloc_rd = '0; cdb_valid = 1'b0;
        cdb_tag = '0; cdb_mispredict = 1'b0; commit_ready = 1'b0;
        #2;
        check_reset("rst0");
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill all eight entries, rd = 1..8
        for (int i = 0; i < 8; i++) begin
            alloc_req = 1'b1; alloc_rd = RW'(i + 1);
            #1;
            chk("fill.alloc_ready", 32'(alloc_ready), 1);
            chk("fill.alloc_tag", 32'(alloc_tag), 32'(i));
            chk("fill.ram_alloc_en", 32'(ram_alloc_en), 1);
            tick();
        end
        alloc_rd = 5'd9;
        #1;
        chk("full.full", 32'(full), 1);
        chk("full.alloc_ready", 32'(alloc_ready), 0);
        chk("full.count", 32'(count), 8);
        chk("full.ram_alloc_en", 32'(ram_alloc_en), 0);
        tick();
        chk("full.count_hold", 32'(count), 8);
        chk("full.tail_wrap", 32'(alloc_tag), 0);

        // Full buffer: retire head while alloc_req waits
        cdb_valid = 1'b1; cdb_tag = 3'd0; commit_ready = 1'b1;
        #1;
        chk("wrap.wb_en", 32'(ram_wb_en), 1);
        chk("wrap.cv_early", 32'(commit_valid), 0);
        chk("wrap.ready_full", 32'(alloc_ready), 0);
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("wrap.cv", 32'(commit_valid), 1);
        chk("wrap.rd", 32'(commit_rd), 1);
        chk("wrap.ready_commit", 32'(alloc_ready), 0);
        chk("wrap.no_alloc", 32'(ram_alloc_en), 0);
        tick();
        #1;
        chk("wrap.count7", 32'(count), 7);
        chk("wrap.ready", 32'(alloc_ready), 1);
        chk("wrap.tag0", 32'(alloc_tag), 0);
        chk("wrap.alloc_en", 32'(ram_alloc_en), 1);
        chk("wrap.head", 32'(ram_head_addr), 1);
        tick();
        alloc_req = 1'b0;
        #1;
        chk("wrap.count8", 32'(count), 8);
        chk("wrap.full", 32'(full), 1);

        // Out-of-order completion 3,1,2 retires 1,2,3 in order
        cdb_valid = 1'b1; cdb_tag = 3'd3;
        #1;
        chk("ooo.c1.cv", 32'(commit_valid), 0);
        tick();
        cdb_tag = 3'd1;
        #1;
        chk("ooo.c2.cv", 32'(commit_valid), 0);
        tick();
        cdb_tag = 3'd2;
        #1;
        chk("ooo.c3.cv", 32'(commit_valid), 1);
        chk("ooo.c3.rd", 32'(commit_rd), 2);
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("ooo.c4.cv", 32'(commit_valid), 1);
        chk("ooo.c4.rd", 32'(commit_rd), 3);
        tick();
        #1;
        chk("ooo.c5.cv", 32'(commit_valid), 1);
        chk("ooo.c5.rd", 32'(commit_rd), 4);
        tick();
        #1;
        chk("ooo.c6.cv", 32'(commit_valid), 0);
        chk("ooo.count", 32'(count), 5);
        chk("ooo.head", 32'(ram_head_addr), 4);

        // Mispredict at tag 1 flushes tags 2,3
        rst = 1'b1;
        #1;
        check_reset("rst1");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alloc_req = 1'b1; alloc_rd = RW'(i + 1);
            #1;
            chk("mp.alloc_tag", 32'(alloc_tag), 32'(i));
            tick();
        end
        alloc_req = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_mispredict = 1'b1;
        #1;
        chk("mp.wb_en", 32'(ram_wb_en), 1);
        tick();
        cdb_tag = 3'd0; cdb_mispredict = 1'b0;
        #1;
        chk("mp.cv0", 32'(commit_valid), 0);
        tick();
        cdb_tag = 3'd2;
        #1;
        chk("mp.cv_tag0", 32'(commit_valid), 1);
        chk("mp.rd_tag0", 32'(commit_rd), 1);
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("mp.cv_tag1", 32'(commit_valid), 1);
        chk("mp.rd_tag1", 32'(commit_rd), 2);
        chk("mp.no_flush_yet", 32'(flush), 0);
        tick();
        alloc_req = 1'b1; alloc_rd = 5'd7;
        #1;
        chk("mp.flush", 32'(flush), 1);
        chk("mp.flush_cv", 32'(commit_valid), 0);
        chk("mp.flush_ready", 32'(alloc_ready), 0);
        chk("mp.flush_alloc_en", 32'(ram_alloc_en), 0);
        chk("mp.flush_head", 32'(ram_head_addr), 2);
        tick();
        #1;
        chk("mp.after_flush", 32'(flush), 0);
        chk("mp.count0", 32'(count), 0);
        chk("mp.empty", 32'(empty), 1);
        chk("mp.tag2", 32'(alloc_tag), 2);
        chk("mp.tag2_no_commit", 32'(commit_valid), 0);
        chk("mp.resume_alloc", 32'(ram_alloc_en), 1);
        tick();
        alloc_req = 1'b0;
        #1;
        chk("mp.count1", 32'(count), 1);
        chk("mp.new_not_done", 32'(commit_valid), 0);

        // Commit back-pressure
        commit_ready = 1'b0; cdb_valid = 1'b1; cdb_tag = 3'd2;
        #1;
        chk("bp.wb_en", 32'(ram_wb_en), 1);
        tick();
        cdb_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp.hold", 32'(commit_valid), 0);
            tick();
        end
        commit_ready = 1'b1;
        #1;
        chk("bp.release_cv", 32'(commit_valid), 1);
        chk("bp.release_rd", 32'(commit_rd), 7);
        tick();
        #1;
        chk("bp.empty", 32'(empty), 1);

        // CDB to a non-busy entry
        cdb_valid = 1'b1; cdb_tag = 3'd5;
        #1;
        chk("err.wb_en", 32'(ram_wb_en), 0);
        chk("err.before", 32'(cdb_err), 0);
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("err.set", 32'(cdb_err), 1);
        tick();
        tick();
        chk("err.sticky", 32'(cdb_err), 1);

        // Drive into FLUSH, then reset mid-flush
        alloc_req = 1'b1; alloc_rd = 5'd9;
        #1;
        chk("rf.alloc_tag", 32'(alloc_tag), 3);
        tick();
        alloc_req = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_mispredict = 1'b1;
        tick();
        cdb_valid = 1'b0; cdb_mispredict = 1'b0;
        #1;
        chk("rf.cv", 32'(commit_valid), 1);
        chk("rf.rd", 32'(commit_rd), 9);
        tick();
        #1;
        chk("rf.flush", 32'(flush), 1);
        chk("rf.err_kept", 32'(cdb_err), 1);
        rst = 1'b1;
        #1;
        check_reset("rst2");
        tick();
        rst = 1'b0;
        #1;
        chk("rf.post_flush", 32'(flush), 0);
        chk("rf.post_ready", 32'(alloc_ready), 1);
        tick();
        chk("rf.post_flush2", 32'(flush), 0);
        chk("rf.post_err", 32'(cdb_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
